mmio_mc_regbank: RTL and testbench
==================================

Name: mmio_mc_regbank

Overview:
- Parametrised multi-bank MMIO slave: standard AFU header, NUM_CSR 64-bit CSRs and NUM_BANKS block-RAM banks, all on one MMIO address space.
- All reads complete with one fixed latency. Supports 4-byte and 8-byte accesses, unmapped-access error tracking and back-to-back reads.
- Sits between the AFU top-level CCI-P c0/c2 decode and user logic. CSR contents are exported to user logic.

Parameters:
- NUM_CSR, 16, number of 64-bit CSRs.
- CSR_BASE, 16'h0020, MMIO dword address of CSR 0.
- NUM_BANKS, 2, number of BRAM banks.
- BANK_WORDS, 512, 64-bit words per bank (power of 2).
- BRAM_BASE, 16'h0080, MMIO dword address of bank 0 word 0.
- RD_LATENCY, 3, cycles from rd_valid to rd_resp_valid (must be >= 2).
- TID_WIDTH, 9, transaction-ID width.
- AFU_ID, 128'h0, value returned at 0x0002/0x0004.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- wr_valid  in  1  MMIO write request
- rd_valid  in  1  MMIO read request
- addr  in  16  MMIO dword address
- len32  in  1  1 = 4-byte access, 0 = 8-byte access
- tid  in  TID_WIDTH  read transaction ID
- wr_data  in  64  write data (4-byte writes use bits 31:0)
- rd_resp_valid  out  1  read response valid
- rd_resp_tid  out  TID_WIDTH  echoed tid
- rd_resp_data  out  64  read data
- csr_out  out  NUM_CSR*64  CSR i at bits [64i+63:64i]
- err_count  out  16  saturating unmapped/misaligned access count

Behaviour:
- Reset:
  - rd_resp_valid=0, rd_resp_tid=0, rd_resp_data=0.
  - All CSRs=0, err_count=0, last_bad_addr=0.
  - Latency pipeline flushed; reads in flight when rst asserts produce no response.
  - BRAM contents are not reset.
- Elaboration check: $error if the CSR range overlaps BRAM_BASE or 0x0000-0x000F.
- Header map (read-only; writes are ignored and not counted as errors):
  - 0x0000: DFH, type=AFU(4'b0001), end-of-list=1, all other fields 0.
  - 0x0002 / 0x0004: AFU_ID[63:0] / AFU_ID[127:64].
  - 0x0006, 0x0008: 0.
  - 0x000A: {32'b0, last_bad_addr[15:0], err_count}.
- CSR i is at CSR_BASE+2i.
  - 8-byte write with addr[0]=0 replaces the whole CSR.
  - 4-byte write: addr[0]=0 updates bits 31:0, addr[0]=1 updates bits 63:32; the other half is unchanged.
- Bank b word w is at BRAM_BASE + b*BANK_WORDS*2 + 2w. Each bank has two 32-bit lane write enables, so 4-byte writes use the same lane rule as CSRs.
- Misaligned access (8-byte with addr[0]=1) and any access outside the header/CSR/bank ranges:
  - Write dropped; read returns 64'h0.
  - err_count increments, saturating at 16'hFFFF; last_bad_addr<=addr.
- Reads:
  - Every rd_valid produces exactly one response exactly RD_LATENCY cycles later, carrying the same tid, for any address.
  - Accepts one read per cycle with no stalls; responses stay in request order.
  - 4-byte read returns the selected dword in bits 31:0, with bits 63:32 zero.
  - Header/CSR data is captured at request time and delayed to match bank latency. Output mux selects on delayed address and len32.
- Ordering:
  - A write in cycle n is visible to a read issued in cycle n+1 or later.
  - rd_valid and wr_valid in the same cycle: both are honoured, and the read returns pre-write data.
- csr_out reflects the register state directly, with zero added latency after the write edge.

Optional Feature:
- MMIO_STATS_EN defined:
  - 0x000C returns a 32-bit wrapping count of accepted rd_valid; 0x000E returns the same for wr_valid. Both are zero-extended to 64 bits and cleared by rst.
  - The read that hits 0x000C reports the count before itself.
- MMIO_STATS_EN undefined: 0x000C/0x000E are unmapped (read 0, err_count increments).

Test Plan:
- Reset, then read 0x0000, tid=5 -> rd_resp_valid after 3 cycles, tid=5, data=64'h1000_0100_0000_0000; err_count=0.
- 8-byte write CSR_BASE+4 = 64'hAAAA_BBBB_CCCC_DDDD, then 4-byte write CSR_BASE+5 = 32'h1234_5678 -> csr_out CSR2 = 64'h1234_5678_CCCC_DDDD; 4-byte read CSR_BASE+4 returns 64'h0000_0000_CCCC_DDDD.
- Write bank1 word0 (0x0480) = 64'h55, read 0x0480 the next cycle -> 64'h55; read 0x0080 (bank0 word0) unaffected.
- 8 back-to-back reads alternating CSR and BRAM addresses, tids 0-7 -> 8 consecutive responses starting cycle 3, tids 0-7 in order with correct data.
- Read 0x0012 (unmapped), then 8-byte write to CSR_BASE+1 -> read returns 0; err_count=2; 0x000A reads {32'b0, 16'h0021, 16'h0002}.
- Issue 2 reads, assert rst 1 cycle later -> no rd_resp_valid for either read; CSRs=0; BRAM data written before reset still reads back.

Source files
------------

// File: rtl/mmio_mc_regbank.sv
// mmio_mc_regbank: MMIO slave with AFU header, NUM_CSR 64-bit CSRs and NUM_BANKS BRAM banks.
// Latency: every read answers exactly RD_LATENCY cycles after rd_valid; writes land at the next edge.
// Backpressure: none, one read and one write per cycle. Define MMIO_STATS_EN to map access counters at 0x000C/0x000E.
module mmio_mc_regbank #(
  parameter int             NUM_CSR    = 16,
  parameter logic [15:0]    CSR_BASE   = 16'h0020,
  parameter int             NUM_BANKS  = 2,
  parameter int             BANK_WORDS = 512,
  parameter logic [15:0]    BRAM_BASE  = 16'h0080,
  parameter int             RD_LATENCY = 3,
  parameter int             TID_WIDTH  = 9,
  parameter logic [127:0]   AFU_ID     = 128'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  input  logic                    rd_valid,
  input  logic [15:0]             addr,
  input  logic                    len32,
  input  logic [TID_WIDTH-1:0]    tid,
  input  logic [63:0]             wr_data,
  output logic                    rd_resp_valid,
  output logic [TID_WIDTH-1:0]    rd_resp_tid,
  output logic [63:0]             rd_resp_data,
  output logic [NUM_CSR*64-1:0]   csr_out,
  output logic [15:0]             err_count
);

  localparam int          CI_W    = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;
  localparam int          WW      = $clog2(BANK_WORDS);
  localparam int          BK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [31:0] CSR_LO  = {16'h0, CSR_BASE};
  localparam logic [31:0] CSR_HI  = CSR_LO + 32'(2 * NUM_CSR);
  localparam logic [31:0] BRAM_LO = {16'h0, BRAM_BASE};
  localparam logic [31:0] BRAM_HI = BRAM_LO + 32'(2 * NUM_BANKS * BANK_WORDS);
  // DFH: feature type AFU in [63:60], end-of-list in bit 40.
  localparam logic [63:0] DFH     = {4'b0001, 19'b0, 1'b1, 40'b0};

  // Reject address maps where the CSR window collides with the header or the banks.
  if (CSR_LO < 32'h10 || (CSR_LO < BRAM_HI && BRAM_LO < CSR_HI)) begin : g_map_err
    $error("mmio_mc_regbank: CSR range overlaps header or BRAM range");
  end
  if (RD_LATENCY < 2) begin : g_lat_err
    $error("mmio_mc_regbank: RD_LATENCY must be >= 2");
  end

  // ---------------- address decode ----------------
  logic            misalign, hdr_map, hdr_hit, csr_hit, bram_hit, good, bad;
  logic [CI_W-1:0] csr_idx;
  logic [WW-1:0]   word_idx;
  logic [BK_W-1:0] bank_idx;

  assign misalign = !len32 && addr[0];
  assign hdr_hit  = (addr[15:4] == 12'h0) && hdr_map;
  assign csr_hit  = ({16'h0, addr} >= CSR_LO) && ({16'h0, addr} < CSR_HI);
  assign bram_hit = ({16'h0, addr} >= BRAM_LO) && ({16'h0, addr} < BRAM_HI);
  assign good     = !misalign && (hdr_hit || csr_hit || bram_hit);
  assign bad      = !good;
  assign csr_idx  = CI_W'((addr - CSR_BASE) >> 1);
  assign word_idx = WW'((addr - BRAM_BASE) >> 1);
  assign bank_idx = BK_W'((addr - BRAM_BASE) >> (WW + 1));

  // Lane enables shared by CSRs and banks: a 4-byte write picks its half with addr[0].
  logic        wr_go, lo_en, hi_en;
  logic [31:0] hi_dat;
  assign wr_go  = wr_valid && good;
  assign lo_en  = !len32 || !addr[0];
  assign hi_en  = !len32 || addr[0];
  assign hi_dat = len32 ? wr_data[31:0] : wr_data[63:32];

  // ---------------- error tracking ----------------
  logic [15:0] last_bad;
  logic [1:0]  nbad;
  logic [16:0] err_sum;
  assign nbad    = bad ? ({1'b0, rd_valid} + {1'b0, wr_valid}) : 2'd0;
  assign err_sum = {1'b0, err_count} + {15'h0, nbad};

  // Count each bad read and bad write, saturating, and remember the offending address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 16'h0;
      last_bad  <= 16'h0;
    end else if (nbad != 2'd0) begin
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      last_bad  <= addr;
    end
  end

`ifdef MMIO_STATS_EN
  logic [31:0] rd_cnt, wr_cnt;
  assign hdr_map = 1'b1;

  // Wrapping counts of every accepted read and write request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= 32'h0;
      wr_cnt <= 32'h0;
    end else begin
      if (rd_valid) rd_cnt <= rd_cnt + 32'd1;
      if (wr_valid) wr_cnt <= wr_cnt + 32'd1;
    end
  end
`else
  assign hdr_map = (addr[3:1] <= 3'd5);
`endif

  // ---------------- CSRs ----------------
  logic [63:0] csr_q [NUM_CSR];

  // CSR writes with per-half lane enables; header writes fall through untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CSR; i++) csr_q[i] <= 64'h0;
    end else if (wr_go && csr_hit) begin
      if (lo_en) csr_q[csr_idx][31:0]  <= wr_data[31:0];
      if (hi_en) csr_q[csr_idx][63:32] <= hi_dat;
    end
  end

  for (genvar i = 0; i < NUM_CSR; i++) begin : g_csr_out
    assign csr_out[64*i +: 64] = csr_q[i];
  end

  // ---------------- BRAM banks ----------------
  logic [63:0] bank_rd [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [63:0] mem [BANK_WORDS];
    logic [63:0] rd_q;
    logic        sel;
    assign sel = bram_hit && (bank_idx == BK_W'(b));

    // Read-first RAM: a same-cycle read sees the pre-write word.
    always_ff @(posedge clk) begin
      if (wr_go && sel) begin
        if (lo_en) mem[word_idx][31:0]  <= wr_data[31:0];
        if (hi_en) mem[word_idx][63:32] <= hi_dat;
      end
      if (rd_valid && sel) rd_q <= mem[word_idx];
    end
    assign bank_rd[b] = rd_q;
  end

  // ---------------- read path ----------------
  logic [63:0] imm;

  // Header/CSR value sampled at request time; unmapped or misaligned reads give zero.
  always_comb begin
    imm = 64'h0;
    if (good && hdr_hit) begin
      case (addr[3:1])
        3'd0:    imm = DFH;
        3'd1:    imm = AFU_ID[63:0];
        3'd2:    imm = AFU_ID[127:64];
        3'd5:    imm = {32'h0, last_bad, err_count};
`ifdef MMIO_STATS_EN
        3'd6:    imm = {32'h0, rd_cnt};
        3'd7:    imm = {32'h0, wr_cnt};
`endif
        default: imm = 64'h0;
      endcase
    end else if (good && csr_hit) begin
      imm = csr_q[csr_idx];
    end
  end

  logic                 s0_vld, s0_len32, s0_hi, s0_bram;
  logic [TID_WIDTH-1:0] s0_tid;
  logic [BK_W-1:0]      s0_bank;
  logic [63:0]          s0_imm, raw, s0_dat;

  // First stage lines up with the bank read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_vld   <= 1'b0;
      s0_tid   <= '0;
      s0_len32 <= 1'b0;
      s0_hi    <= 1'b0;
      s0_bram  <= 1'b0;
      s0_bank  <= '0;
      s0_imm   <= 64'h0;
    end else begin
      s0_vld   <= rd_valid;
      s0_tid   <= tid;
      s0_len32 <= len32;
      s0_hi    <= addr[0];
      s0_bram  <= good && bram_hit;
      s0_bank  <= bank_idx;
      s0_imm   <= imm;
    end
  end

  // Select bank or captured data, then narrow 4-byte reads to the addressed dword.
  always_comb begin
    raw    = s0_bram ? bank_rd[s0_bank] : s0_imm;
    s0_dat = 64'h0;
    if (s0_vld) begin
      if (s0_len32) s0_dat = {32'h0, s0_hi ? raw[63:32] : raw[31:0]};
      else          s0_dat = raw;
    end
  end

  logic                 p_vld [RD_LATENCY-1];
  logic [TID_WIDTH-1:0] p_tid [RD_LATENCY-1];
  logic [63:0]          p_dat [RD_LATENCY-1];

  // Delay line padding the response out to RD_LATENCY; the last entry drives the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY-1; i++) begin
        p_vld[i] <= 1'b0;
        p_tid[i] <= '0;
        p_dat[i] <= 64'h0;
      end
    end else begin
      p_vld[0] <= s0_vld;
      p_tid[0] <= s0_tid;
      p_dat[0] <= s0_dat;
      for (int i = 1; i < RD_LATENCY-1; i++) begin
        p_vld[i] <= p_vld[i-1];
        p_tid[i] <= p_tid[i-1];
        p_dat[i] <= p_dat[i-1];
      end
    end
  end

  assign rd_resp_valid = p_vld[RD_LATENCY-2];
  assign rd_resp_tid   = p_tid[RD_LATENCY-2];
  assign rd_resp_data  = p_dat[RD_LATENCY-2];

endmodule

// File: tb/tb_mmio_mc_regbank.sv
// tb_mmio_mc_regbank: directed bench for mmio_mc_regbank with default parameters.
// Responses are collected at negedge with the cycle they appeared in.
// Expected values are hand-computed constants.
module tb_mmio_mc_regbank;

  logic          clk, rst, wr_valid, rd_valid, len32;
  logic [15:0]   addr;
  logic [8:0]    tid;
  logic [63:0]   wr_data;
  logic          rd_resp_valid;
  logic [8:0]    rd_resp_tid;
  logic [63:0]   rd_resp_data;
  logic [1023:0] csr_out;
  logic [15:0]   err_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int         q_cyc [$];
  logic [8:0] q_tid [$];
  logic [63:0] q_dat [$];

  mmio_mc_regbank dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .rd_valid      (rd_valid),
    .addr          (addr),
    .len32         (len32),
    .tid           (tid),
    .wr_data       (wr_data),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_tid   (rd_resp_tid),
    .rd_resp_data  (rd_resp_data),
    .csr_out       (csr_out),
    .err_count     (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rd_resp_valid === 1'b1) begin
      q_cyc.push_back(cyc);
      q_tid.push_back(rd_resp_tid);
      q_dat.push_back(rd_resp_data);
    end
  end

  function automatic int rc(int i);
    return (i < q_cyc.size()) ? q_cyc[i] : -1;
  endfunction
  function automatic logic [8:0] rt(int i);
    return (i < q_tid.size()) ? q_tid[i] : 9'bx;
  endfunction
  function automatic logic [63:0] rdat(int i);
    return (i < q_dat.size()) ? q_dat[i] : 64'bx;
  endfunction

  task automatic clear_q();
    q_cyc.delete();
    q_tid.delete();
    q_dat.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_rd(input logic [15:0] a, input logic l, input logic [8:0] t, output int issued);
    rd_valid = 1'b1; addr = a; len32 = l; tid = t;
    issued = cyc;
    @(posedge clk); #1;
    rd_valid = 1'b0;
  endtask

  task automatic drive_wr(input logic [15:0] a, input logic l, input logic [63:0] d);
    wr_valid = 1'b1; addr = a; len32 = l; wr_data = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic drive_rw(input logic [15:0] a, input logic [63:0] d, input logic [8:0] t);
    rd_valid = 1'b1; wr_valid = 1'b1; addr = a; len32 = 1'b0; wr_data = d; tid = t;
    @(posedge clk); #1;
    rd_valid = 1'b0; wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++; if (rd_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rd_resp_valid); end
    checks++; if (rd_resp_tid !== 9'h0) begin errors++; $display("FAIL reset_tid got %h exp 0", rd_resp_tid); end
    checks++; if (rd_resp_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", rd_resp_data); end
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL reset_err got %h exp 0", err_count); end
    checks++; if (csr_out !== '0) begin errors++; $display("FAIL reset_csr got nonzero exp 0"); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_dfh();
    int iss;
    clear_q();
    drive_rd(16'h0000, 1'b0, 9'd5, iss);
    idle(5);
    checks++; if (q_cyc.size() != 1) begin errors++; $display("FAIL dfh_count got %0d exp 1", q_cyc.size()); end
    checks++; if (rc(0) != iss + 3) begin errors++; $display("FAIL dfh_latency got %0d exp %0d", rc(0), iss + 3); end
    checks++; if (rt(0) !== 9'd5) begin errors++; $display("FAIL dfh_tid got %h exp 5", rt(0)); end
    checks++; if (rdat(0) !== 64'h1000_0100_0000_0000) begin errors++; $display("FAIL dfh_data got %h exp 1000010000000000", rdat(0)); end
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL dfh_err got %h exp 0", err_count); end
  endtask

  task automatic test_csr_lanes();
    int iss;
    drive_wr(16'h0024, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD);
    checks++; if (csr_out[128 +: 64] !== 64'hAAAA_BBBB_CCCC_DDDD) begin errors++; $display("FAIL csr2_full got %h exp aaaabbbbccccdddd", csr_out[128 +: 64]); end
    drive_wr(16'h0025, 1'b1, 64'hFFFF_FFFF_1234_5678);
    checks++; if (csr_out[128 +: 64] !== 64'h1234_5678_CCCC_DDDD) begin errors++; $display("FAIL csr2_hi got %h exp 12345678ccccdddd", csr_out[128 +: 64]); end
    checks++; if (csr_out[64 +: 64] !== 64'h0) begin errors++; $display("FAIL csr1_untouched got %h exp 0", csr_out[64 +: 64]); end
    clear_q();
    drive_rd(16'h0024, 1'b1, 9'd3, iss);
    drive_rd(16'h0025, 1'b1, 9'd4, iss);
    drive_rd(16'h0024, 1'b0, 9'd6, iss);
    idle(5);
    checks++; if (q_cyc.size() != 3) begin errors++; $display("FAIL csr_rd_count got %0d exp 3", q_cyc.size()); end
    checks++; if (rdat(0) !== 64'h0000_0000_CCCC_DDDD) begin errors++; $display("FAIL csr_rd_lo got %h exp 00000000ccccdddd", rdat(0)); end
    checks++; if (rdat(1) !== 64'h0000_0000_1234_5678) begin errors++; $display("FAIL csr_rd_hi got %h exp 0000000012345678", rdat(1)); end
    checks++; if (rdat(2) !== 64'h1234_5678_CCCC_DDDD) begin errors++; $display("FAIL csr_rd_full got %h exp 12345678ccccdddd", rdat(2)); end
    checks++; if (rt(2) !== 9'd6) begin errors++; $display("FAIL csr_rd_tid got %h exp 6", rt(2)); end
  endtask

  task automatic test_bram();
    int iss;
    drive_wr(16'h0080, 1'b0, 64'h0123_4567_89AB_CDEF);
    drive_wr(16'h0480, 1'b0, 64'h55);
    clear_q();
    drive_rd(16'h0480, 1'b0, 9'd1, iss);
    drive_rd(16'h0080, 1'b0, 9'd2, iss);
    idle(5);
    checks++; if (rdat(0) !== 64'h55) begin errors++; $display("FAIL bram_b1w0 got %h exp 55", rdat(0)); end
    checks++; if (rdat(1) !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL bram_b0w0 got %h exp 0123456789abcdef", rdat(1)); end
    drive_wr(16'h0481, 1'b1, 64'h0000_0000_DEAD_BEEF);
    clear_q();
    drive_rd(16'h0480, 1'b0, 9'd3, iss);
    idle(5);
    checks++; if (rdat(0) !== 64'hDEAD_BEEF_0000_0055) begin errors++; $display("FAIL bram_lane got %h exp deadbeef00000055", rdat(0)); end
    checks++; if (rc(0) != iss + 3) begin errors++; $display("FAIL bram_latency got %0d exp %0d", rc(0), iss + 3); end
  endtask

  task automatic test_same_cycle();
    int iss;
    drive_wr(16'h0482, 1'b0, 64'h11);
    clear_q();
    drive_rw(16'h0482, 64'h22, 9'd7);
    drive_rw(16'h0026, 64'h77, 9'd8);
    drive_rd(16'h0482, 1'b0, 9'd9, iss);
    idle(5);
    checks++; if (rdat(0) !== 64'h11) begin errors++; $display("FAIL rw_bram_old got %h exp 11", rdat(0)); end
    checks++; if (rdat(1) !== 64'h0) begin errors++; $display("FAIL rw_csr_old got %h exp 0", rdat(1)); end
    checks++; if (rdat(2) !== 64'h22) begin errors++; $display("FAIL rw_bram_new got %h exp 22", rdat(2)); end
    checks++; if (csr_out[192 +: 64] !== 64'h77) begin errors++; $display("FAIL rw_csr3 got %h exp 77", csr_out[192 +: 64]); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ba [4];
    logic [63:0] bd [4];
    int iss, first;
    ba[0] = 16'h0024; bd[0] = 64'h1234_5678_CCCC_DDDD;
    ba[1] = 16'h0480; bd[1] = 64'hDEAD_BEEF_0000_0055;
    ba[2] = 16'h0026; bd[2] = 64'h77;
    ba[3] = 16'h0080; bd[3] = 64'h0123_4567_89AB_CDEF;
    first = 0;
    clear_q();
    for (int i = 0; i < 8; i++) begin
      drive_rd(ba[i % 4], 1'b0, 9'(i), iss);
      if (i == 0) first = iss;
    end
    idle(6);
    checks++; if (q_cyc.size() != 8) begin errors++; $display("FAIL b2b_count got %0d exp 8", q_cyc.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rc(i) != first + 3 + i) begin errors++; $display("FAIL b2b_cycle[%0d] got %0d exp %0d", i, rc(i), first + 3 + i); end
      checks++; if (rt(i) !== 9'(i)) begin errors++; $display("FAIL b2b_tid[%0d] got %h exp %h", i, rt(i), 9'(i)); end
      checks++; if (rdat(i) !== bd[i % 4]) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, rdat(i), bd[i % 4]); end
    end
  endtask

  task automatic test_errors();
    int iss;
    clear_q();
    drive_rd(16'h0012, 1'b0, 9'd9, iss);
    drive_wr(16'h0021, 1'b0, 64'hFFFF);
    idle(1);
    checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL err_two got %h exp 2", err_count); end
    checks++; if (csr_out[63:0] !== 64'h0) begin errors++; $display("FAIL err_wr_dropped got %h exp 0", csr_out[63:0]); end
    drive_rd(16'h000A, 1'b0, 9'd10, iss);
    idle(5);
    checks++; if (rdat(0) !== 64'h0) begin errors++; $display("FAIL err_rd_zero got %h exp 0", rdat(0)); end
    checks++; if (rt(0) !== 9'd9) begin errors++; $display("FAIL err_rd_tid got %h exp 9", rt(0)); end
    checks++; if (rdat(1) !== 64'h0000_0000_0021_0002) begin errors++; $display("FAIL err_status got %h exp 0000000000210002", rdat(1)); end
    drive_wr(16'h000A, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    drive_wr(16'h003E, 1'b0, 64'h99);
    idle(1);
    checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL err_hdr_wr got %h exp 2", err_count); end
    checks++; if (csr_out[960 +: 64] !== 64'h99) begin errors++; $display("FAIL csr15 got %h exp 99", csr_out[960 +: 64]); end
    drive_wr(16'h0040, 1'b0, 64'h1);
    idle(1);
    checks++; if (err_count !== 16'd3) begin errors++; $display("FAIL err_csr_end got %h exp 3", err_count); end
    clear_q();
    drive_wr(16'h087E, 1'b0, 64'hABCD);
    drive_rd(16'h087E, 1'b0, 9'd20, iss);
    drive_rd(16'h0880, 1'b0, 9'd21, iss);
    idle(5);
    checks++; if (rdat(0) !== 64'hABCD) begin errors++; $display("FAIL bram_last got %h exp abcd", rdat(0)); end
    checks++; if (rdat(1) !== 64'h0) begin errors++; $display("FAIL bram_past_end got %h exp 0", rdat(1)); end
    checks++; if (err_count !== 16'd4) begin errors++; $display("FAIL err_bram_end got %h exp 4", err_count); end
`ifndef MMIO_STATS_EN
    clear_q();
    drive_rd(16'h000C, 1'b0, 9'd22, iss);
    idle(5);
    checks++; if (rdat(0) !== 64'h0) begin errors++; $display("FAIL stats_off_rd got %h exp 0", rdat(0)); end
    checks++; if (err_count !== 16'd5) begin errors++; $display("FAIL stats_off_err got %h exp 5", err_count); end
`endif
  endtask

  task automatic test_reset_flush();
    int iss;
    clear_q();
    drive_rd(16'h0480, 1'b0, 9'd12, iss);
    drive_rd(16'h0024, 1'b0, 9'd13, iss);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(5);
    checks++; if (q_cyc.size() != 0) begin errors++; $display("FAIL flush_count got %0d exp 0", q_cyc.size()); end
    checks++; if (csr_out !== '0) begin errors++; $display("FAIL flush_csr got nonzero exp 0"); end
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL flush_err got %h exp 0", err_count); end
    clear_q();
    drive_rd(16'h0480, 1'b0, 9'd14, iss);
    drive_rd(16'h0080, 1'b0, 9'd15, iss);
    drive_rd(16'h0024, 1'b0, 9'd16, iss);
    idle(5);
    checks++; if (rdat(0) !== 64'hDEAD_BEEF_0000_0055) begin errors++; $display("FAIL flush_bram1 got %h exp deadbeef00000055", rdat(0)); end
    checks++; if (rdat(1) !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL flush_bram0 got %h exp 0123456789abcdef", rdat(1)); end
    checks++; if (rdat(2) !== 64'h0) begin errors++; $display("FAIL flush_csr_rd got %h exp 0", rdat(2)); end
    checks++; if (rt(2) !== 9'd16) begin errors++; $display("FAIL flush_tid got %h exp 10", rt(2)); end
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; len32 = 1'b0;
    addr = 16'h0; tid = 9'h0; wr_data = 64'h0;
    test_reset();
    test_dfh();
    test_csr_lanes();
    test_bram();
    test_same_cycle();
    test_back_to_back();
    test_errors();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
